adexp_spike_encoder: RTL and testbench

//  Digital back end of the DPI AdExp neuron tile. Synchronises the analog core's

---
 rtl/adexp_spike_encoder.sv | 171 +++++++++++++++++
 tb/tb_adexp_spike_encoder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adexp_spike_encoder.sv
// AdExp neuron tile back end: spike sync, refractory edge detect,
// ISI timestamping, ISI FIFO and byte-wide valid/ready streaming.
module adexp_spike_encoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int REFRAC      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spike_in,
  input  logic       en,
  input  logic       clr_ovf,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] spike_cnt,
  output logic       ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(REFRAC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HI,
    ST_LO
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d1_q, s_d1_d;
  logic [RW-1:0]          refrac_q, refrac_d;
  logic [15:0]            isi_q, isi_d;
  logic [7:0]             spike_cnt_q, spike_cnt_d;
  logic                   ovf_q, ovf_d;
  logic [AW:0]            wr_q, wr_d;
  logic [AW:0]            rd_q, rd_d;
  logic [15:0]            mem_q [FIFO_DEPTH];

  state_e      state_q;
  logic [15:0] hold_q;
  logic [7:0]  out_data_q;
  logic        out_valid_q;
  logic        out_last_q;

  logic        spk_edge;
  logic        accept;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        drop;
  logic [15:0] rd_data;

  assign spk_edge = sync_q[SYNC_STAGES-1] & ~s_d1_q;
  assign accept   = spk_edge & en & (refrac_q == '0);
  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_data  = mem_q[rd_q[AW-1:0]];

  // IDLE pops whenever data waits; LO pops only on handshake (no bubble)
  assign pop  = ~empty & ((state_q == ST_IDLE) |
                          ((state_q == ST_LO) & out_ready));
  assign push = accept & (~full | pop);
  assign drop = accept & full & ~pop;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], spike_in};
    s_d1_d      = sync_q[SYNC_STAGES-1];
    refrac_d    = refrac_q;
    isi_d       = isi_q;
    spike_cnt_d = spike_cnt_q;
    ovf_d       = ovf_q;
    wr_d        = wr_q + (AW+1)'(push);
    rd_d        = rd_q + (AW+1)'(pop);
    if (accept) begin
      refrac_d    = RW'(REFRAC);
      isi_d       = 16'd1;
      spike_cnt_d = spike_cnt_q + 8'd1;
    end else begin
      if (refrac_q != '0)
        refrac_d = refrac_q - RW'(1);
      if (en && isi_q != 16'hFFFF)
        isi_d = isi_q + 16'd1;
    end
    if (drop)
      ovf_d = 1'b1;
    else if (clr_ovf)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      s_d1_q      <= 1'b0;
      refrac_q    <= '0;
      isi_q       <= '0;
      spike_cnt_q <= '0;
      ovf_q       <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
    end else begin
      sync_q      <= sync_d;
      s_d1_q      <= s_d1_d;
      refrac_q    <= refrac_d;
      isi_q       <= isi_d;
      spike_cnt_q <= spike_cnt_d;
      ovf_q       <= ovf_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q[AW-1:0]] <= isi_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q     <= ST_HI;
            hold_q      <= rd_data;
            out_data_q  <= rd_data[15:8];
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end
        ST_HI: begin
          if (out_ready) begin
            state_q    <= ST_LO;
            out_data_q <= hold_q[7:0];
            out_last_q <= 1'b1;
          end
        end
        ST_LO: begin
          if (out_ready) begin
            if (pop) begin
              state_q     <= ST_HI;
              hold_q      <= rd_data;
              out_data_q  <= rd_data[15:8];
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
            end else begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign spike_cnt = spike_cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adexp_spike_encoder.sv
// Bench for adexp_spike_encoder: directed and random spike trains
// against an ISI/refractory reference model and a byte monitor.
module tb_adexp_spike_encoder;

  localparam int FD = 4;
  localparam int RF = 8;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spike_in;
  logic       en;
  logic       clr_ovf;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic [7:0] spike_cnt;
  logic       ovf;

  adexp_spike_encoder #(
    .FIFO_DEPTH (FD),
    .REFRAC     (RF),
    .SYNC_STAGES(SS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .spike_in (spike_in),
    .en       (en),
    .clr_ovf  (clr_ovf),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .spike_cnt(spike_cnt),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_cnt = 0;

  // reference model state
  int          last_en;
  int          last_cyc;
  bit          have_acc;
  int          exp_cnt;
  bit          exp_ovf;
  bit          stall;
  bit          rnd_rdy;
  logic [15:0] expq[$];
  logic [8:0]  rx[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst && en) en_cnt++;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // byte monitor plus hold-stability check while stalled
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic       pl = 1'b0;
  logic [7:0] pd = '0;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr)
        check("stable", {22'd0, out_valid, out_last, out_data},
              {22'd0, 1'b1, pl, pd});
      if (out_valid && out_ready)
        rx.push_back({out_last, out_data});
      pv = out_valid;
      pr = out_ready;
      pl = out_last;
      pd = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic model_clear();
    last_en  = -SS;
    last_cyc = 0;
    have_acc = 1'b0;
    exp_cnt  = 0;
    exp_ovf  = 1'b0;
    expq.delete();
    rx.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    spike_in = 1'b0;
    clr_ovf  = 1'b0;
    model_clear();
    idle(2);
    en_cnt = 0;
    rst    = 1'b0;
  endtask

  // one-cycle pulse; ISI is the count of en cycles between accepted rises
  task automatic spike();
    int d;
    spike_in = 1'b1;
    if (en && (!have_acc || cyc - last_cyc > RF)) begin
      d        = en_cnt - last_en;
      last_en  = en_cnt;
      last_cyc = cyc;
      have_acc = 1'b1;
      exp_cnt++;
      if (stall && expq.size() >= FD + 1)
        exp_ovf = 1'b1;
      else
        expq.push_back(d > 65535 ? 16'hFFFF : 16'(d));
    end
    tick();
    spike_in = 1'b0;
  endtask

  task automatic drain(string tag);
    int n;
    int k;
    logic [15:0] w;
    n = expq.size();
    k = 0;
    while (rx.size() < 2 * n && k < 4000) begin
      tick();
      k++;
    end
    idle(4);
    check({tag, "_bytes"}, rx.size(), 2 * n);
    while (expq.size() > 0 && rx.size() >= 2) begin
      w = expq.pop_front();
      check({tag, "_word"}, {14'd0, rx[0], rx[1]},
            {14'd0, 1'b0, w[15:8], 1'b1, w[7:0]});
      void'(rx.pop_front());
      void'(rx.pop_front());
    end
    expq.delete();
    rx.delete();
    check({tag, "_spike_cnt"}, {24'd0, spike_cnt}, exp_cnt & 255);
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  initial begin
    spike_in  = 1'b0;
    en        = 1'b0;
    clr_ovf   = 1'b0;
    out_ready = 1'b0;
    stall     = 1'b0;
    rnd_rdy   = 1'b0;
    #1;
    do_reset();
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_data", {24'd0, out_data}, 0);
    check("rst_last", {31'd0, out_last}, 0);
    check("rst_spike_cnt", {24'd0, spike_cnt}, 0);
    check("rst_ovf", {31'd0, ovf}, 0);
    en        = 1'b1;
    out_ready = 1'b1;

    // T1: two spikes 50 cycles apart, first one 100 en cycles after reset
    while (en_cnt < 98) tick();
    spike();
    while (en_cnt < 148) tick();
    spike();
    drain("t1");

    // T2: refractory lockout including the gap 8 / gap 9 boundary
    idle(20);
    spike();
    idle(2);
    spike();
    idle(9);
    spike();
    idle(7);
    spike();
    idle(20);
    spike();
    idle(8);
    spike();
    drain("t2");

    // en low freezes the ISI count and blocks detection
    idle(15);
    spike();
    idle(10);
    en = 1'b0;
    idle(5);
    spike();
    idle(20);
    en = 1'b1;
    idle(10);
    spike();
    drain("en_gate");

    // T3: stalled consumer overflows the FIFO
    out_ready = 1'b0;
    stall     = 1'b1;
    repeat (FD + 2) begin
      spike();
      idle(11);
    end
    check("t3_ovf_set", {31'd0, ovf}, {31'd0, exp_ovf});
    out_ready = 1'b1;
    drain("t3");
    stall   = 1'b0;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    exp_ovf = 1'b0;
    check("t3_ovf_clr", {31'd0, ovf}, 0);

    // T5: random gaps and random back-pressure
    rnd_rdy = 1'b1;
    repeat (40) begin
      spike();
      idle($urandom_range(1, 28));
    end
    drain("t5");
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;

    // spike_cnt wraps past 255
    repeat (260) begin
      spike();
      idle(9);
    end
    drain("wrap");

    // T4: ISI saturation
    do_reset();
    idle(70000);
    spike();
    drain("t4");

    // T6: reset while in LO with two words still queued
    out_ready = 1'b0;
    repeat (3) begin
      spike();
      idle(11);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t6_in_lo", {22'd0, out_valid, out_last, out_data},
          {22'd0, 1'b1, 1'b1, expq[0][7:0]});
    rst = 1'b1;
    #1;
    check("t6_rst_outs", {21'd0, out_valid, out_last, ovf, out_data},
          0);
    check("t6_rst_cnt", {24'd0, spike_cnt}, 0);
    model_clear();
    idle(2);
    en_cnt    = 0;
    rst       = 1'b0;
    out_ready = 1'b1;
    idle(40);
    check("t6_no_bytes", rx.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
